// File: rtl/piso_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module : piso_tx_ctrl
// Brief  : Valid/ready front end and load/shift sequencer for a PISO register.
// Rev    : 1.0  initial release
// ============================================================================
module piso_tx_ctrl #(
   parameter int WIDTH = 4,
   parameter int GAP   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_ready,
   output logic             o_ld,
   output logic [WIDTH-1:0] o_pin,
   output logic             o_frame,
   output logic             o_last,
   output logic             o_busy
);

   localparam int             c_cw       = $clog2(WIDTH);
   localparam logic [c_cw-1:0] c_last_cnt = c_cw'(WIDTH - 1);
   localparam logic [3:0]      c_gap_last = 4'(GAP - 1);
   localparam logic            c_no_gap   = (GAP == 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [c_cw-1:0] r_cnt;
   logic [c_cw-1:0] w_cnt_nxt;
   logic [3:0]      r_gcnt;
   logic [3:0]      w_gcnt_nxt;
   logic            w_cnt_end;
   logic            w_gap_end;
   logic            w_slot;
   logic            w_accept;

   assign w_cnt_end = (r_cnt == c_last_cnt);
   assign w_gap_end = (r_gcnt == c_gap_last);

   always_comb begin
      w_slot = 1'b0;
      case (r_state)
         S_IDLE:  w_slot = 1'b1;
         S_SHIFT: w_slot = w_cnt_end & c_no_gap;
         S_GAP:   w_slot = w_gap_end;
         default: w_slot = 1'b0;
      endcase
   end

   // The slot is gated by reset so no load can leak out while rst_n is low.
   assign o_ready  = rst_n & w_slot;
   assign w_accept = i_valid & o_ready;
   assign o_ld     = w_accept;
   assign o_pin    = i_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_gcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_gcnt  <= w_gcnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_gcnt_nxt  = r_gcnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_SHIFT;
               w_cnt_nxt   = '0;
            end
         end
         S_SHIFT: begin
            if (!w_cnt_end) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end else if (!c_no_gap) begin
               w_state_nxt = S_GAP;
               w_gcnt_nxt  = '0;
            end else if (w_accept) begin
               w_cnt_nxt = '0;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_GAP: begin
            if (!w_gap_end) begin
               w_gcnt_nxt = r_gcnt + 4'd1;
            end else if (w_accept) begin
               w_state_nxt = S_SHIFT;
               w_cnt_nxt   = '0;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign o_frame = (r_state == S_SHIFT);
   assign o_last  = o_frame & w_cnt_end;
   assign o_busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire
